// File: rtl/alu_result_if.sv
// Handshake bundle between the ALU, the result stage and writeback.
// master = surrounding environment (ALU producer + writeback consumer), slave = result stage.
interface alu_result_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_dout;
    logic              in_cout;
    logic [2:0]        in_control;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_dout, in_cout, in_control, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_dout, in_cout, in_control, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/alu_result_stage.sv
// Two-entry result buffer between the ALU and writeback; updates status
// flags and a retired-result counter as entries are popped.
module alu_result_stage #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_result_if.slave      bus,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic [CNT_W-1:0] retired_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t            state;
    logic              wr_ptr;
    logic              rd_ptr;
    logic              ready_q;
    logic              valid_q;

    // Carry-class bit is decoded at push time so only it needs storing.
    logic [DATA_W-1:0] mem_data [2];
    logic [TAG_W-1:0]  mem_tag  [2];
    logic              mem_cout [2];
    logic              mem_cls  [2];

    logic push;
    logic pop;

    assign push = bus.in_valid && ready_q;
    assign pop  = valid_q && bus.out_ready;

    assign bus.in_ready  = ready_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = mem_data[rd_ptr];
    assign bus.out_tag   = mem_tag[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
            flag_z      <= 1'b0;
            flag_n      <= 1'b0;
            flag_c      <= 1'b0;
            retired_cnt <= '0;
            // NOTE: the buffer is cleared on reset so out_data/out_tag read 0
            // after reset; a plain RAM without reset would expose stale data.
            for (int i = 0; i < 2; i++) begin
                mem_data[i] <= '0;
                mem_tag[i]  <= '0;
                mem_cout[i] <= 1'b0;
                mem_cls[i]  <= 1'b0;
            end
        end else begin
            // NOTE: all state here uses non-blocking assignments so every read
            // in this block sees pre-edge values regardless of statement order.
            case (state)
                EMPTY: begin
                    if (push) begin
                        state   <= ONE;
                        valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state   <= FULL;
                        ready_q <= 1'b0;
                    end else if (!push && pop) begin
                        state   <= EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state   <= ONE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase

            if (push) begin
                mem_data[wr_ptr] <= bus.in_dout;
                mem_tag[wr_ptr]  <= bus.in_tag;
                mem_cout[wr_ptr] <= bus.in_cout;
                mem_cls[wr_ptr]  <= (bus.in_control[2:1] == 2'b00);
                wr_ptr           <= ~wr_ptr;
            end

            if (pop) begin
                rd_ptr      <= ~rd_ptr;
                flag_z      <= (mem_data[rd_ptr] == '0);
                flag_n      <= mem_data[rd_ptr][DATA_W-1];
                if (mem_cls[rd_ptr]) begin
                    flag_c <= mem_cout[rd_ptr];
                end
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage.
module tb_alu_result_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flag_z;
    logic        flag_n;
    logic        flag_c;
    logic [15:0] retired_cnt;

    int n_checks = 0;
    int n_errors = 0;

    alu_result_if #(.DATA_W(32), .TAG_W(5)) bus ();

    alu_result_stage #(.DATA_W(32), .TAG_W(5), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .flag_c      (flag_c),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic c,
                         input logic [2:0] ctl, input logic [4:0] t);
        bus.in_valid   = v;
        bus.in_dout    = d;
        bus.in_cout    = c;
        bus.in_control = ctl;
        bus.in_tag     = t;
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0, 3'b000, 5'd0);
        bus.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'h0);
        check("rst_out_tag", 32'(bus.out_tag), 32'd0);
        check("rst_flags", {29'd0, flag_z, flag_n, flag_c}, 32'd0);
        check("rst_cnt", 32'(retired_cnt), 32'd0);

        // Zero result from an add: sets Z and C
        drive(1'b1, 32'h0000_0000, 1'b1, 3'b000, 5'd3);
        step();
        drive(1'b0, 32'hDEAD_BEEF, 1'b0, 3'b000, 5'd9);
        check("zero_out_valid", 32'(bus.out_valid), 32'd1);
        check("zero_out_data", bus.out_data, 32'h0);
        check("zero_out_tag", 32'(bus.out_tag), 32'd3);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("zero_flag_z", 32'(flag_z), 32'd1);
        check("zero_flag_c", 32'(flag_c), 32'd1);
        check("zero_flag_n", 32'(flag_n), 32'd0);
        check("zero_cnt", 32'(retired_cnt), 32'd1);
        check("zero_drained", 32'(bus.out_valid), 32'd0);

        // Negative result from a non-arithmetic code: C holds at 1
        drive(1'b1, 32'h8000_0001, 1'b0, 3'b110, 5'd7);
        step();
        drive(1'b0, 32'h0, 1'b0, 3'b000, 5'd0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("neg_flag_n", 32'(flag_n), 32'd1);
        check("neg_flag_z", 32'(flag_z), 32'd0);
        check("neg_flag_c_hold", 32'(flag_c), 32'd1);
        check("neg_cnt", 32'(retired_cnt), 32'd2);

        // Subtract class with cout=0 clears C
        drive(1'b1, 32'h0000_0005, 1'b0, 3'b001, 5'd4);
        step();
        drive(1'b0, 32'h0, 1'b0, 3'b000, 5'd0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("sub_flag_c", 32'(flag_c), 32'd0);
        check("sub_flags_zn", {30'd0, flag_z, flag_n}, 32'd0);
        check("sub_cnt", 32'(retired_cnt), 32'd3);

        // Backpressure: fill, reject a third push, then drain in order
        drive(1'b1, 32'h0000_000A, 1'b0, 3'b010, 5'd1);
        step();
        check("bp_first_ready", 32'(bus.in_ready), 32'd1);
        check("bp_first_data", bus.out_data, 32'hA);
        drive(1'b1, 32'h0000_000B, 1'b0, 3'b010, 5'd2);
        step();
        check("bp_full_ready", 32'(bus.in_ready), 32'd0);
        check("bp_full_data", bus.out_data, 32'hA);
        drive(1'b1, 32'h0000_000C, 1'b1, 3'b000, 5'd3);
        step();
        check("bp_hold_data", bus.out_data, 32'hA);
        check("bp_hold_tag", 32'(bus.out_tag), 32'd1);
        check("bp_hold_ready", 32'(bus.in_ready), 32'd0);
        drive(1'b0, 32'h0, 1'b0, 3'b000, 5'd0);
        bus.out_ready = 1'b1;
        step();
        check("bp_pop1_data", bus.out_data, 32'hB);
        check("bp_pop1_tag", 32'(bus.out_tag), 32'd2);
        check("bp_pop1_ready", 32'(bus.in_ready), 32'd1);
        check("bp_pop1_valid", 32'(bus.out_valid), 32'd1);
        step();
        bus.out_ready = 1'b0;
        check("bp_pop2_valid", 32'(bus.out_valid), 32'd0);
        check("bp_cnt", 32'(retired_cnt), 32'd5);
        check("bp_flag_c_hold", 32'(flag_c), 32'd0);

        // Asynchronous reset with buffer full and flags set
        drive(1'b1, 32'h0, 1'b1, 3'b000, 5'd6);
        bus.out_ready = 1'b1;
        step();
        drive(1'b0, 32'h0, 1'b0, 3'b000, 5'd0);
        step();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h1111_1111, 1'b0, 3'b010, 5'd1);
        step();
        drive(1'b1, 32'h2222_2222, 1'b0, 3'b010, 5'd2);
        step();
        drive(1'b0, 32'h0, 1'b0, 3'b000, 5'd0);
        check("pre_rst_full", 32'(bus.in_ready), 32'd0);
        check("pre_rst_flags", {29'd0, flag_z, flag_n, flag_c}, 32'b101);
        #1 rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        check("arst_flags", {29'd0, flag_z, flag_n, flag_c}, 32'd0);
        check("arst_cnt", 32'(retired_cnt), 32'd0);
        check("arst_out_data", bus.out_data, 32'h0);
        step();
        rst = 1'b0;

        // Sustained streaming, one result per cycle
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            drive(1'b1, 32'h1000 + 32'(k - 1), 1'b0, 3'b011, 5'(k));
            step();
            check("stream_data", bus.out_data, 32'h1000 + 32'(k - 1));
            check("stream_cnt", 32'(retired_cnt), 32'(k - 1));
            check("stream_ready", 32'(bus.in_ready), 32'd1);
        end
        drive(1'b0, 32'h0, 1'b0, 3'b000, 5'd0);
        step();
        check("stream_final_cnt", 32'(retired_cnt), 32'd100);
        check("stream_drained", 32'(bus.out_valid), 32'd0);

        // Counter wrap at 2^16
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 65535; k++) begin
            drive(1'b1, 32'(k), 1'b0, 3'b011, 5'd0);
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 3'b000, 5'd0);
        step();
        check("wrap_max_cnt", 32'(retired_cnt), 32'h0000_FFFF);
        drive(1'b1, 32'h5, 1'b0, 3'b011, 5'd0);
        step();
        drive(1'b0, 32'h0, 1'b0, 3'b000, 5'd0);
        step();
        check("wrap_zero_cnt", 32'(retired_cnt), 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
